// File: rtl/retire_trace_pkg.sv
// retire_trace_pkg: shared types for the retirement trace shadow pipeline
package retire_trace_pkg;
  localparam int RT_XLEN = 32;
  typedef enum logic [1:0] {
    T_R    = 2'd0,
    T_I    = 2'd1,
    T_J    = 2'd2,
    T_NONE = 2'd3
  } instr_type_t;
  typedef struct packed {
    logic [RT_XLEN-1:0] pc;
    logic [RT_XLEN-1:0] instr;
    instr_type_t        itype;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [RT_XLEN-1:0] rs_val;
    logic [RT_XLEN-1:0] rt_val;
    logic [RT_XLEN-1:0] dest_val;
    logic               dest_wr;
  } retire_rec_t;
endpackage

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: synchronous record FIFO with a registered head (no fall-through)
module retire_trace_fifo
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  retire_rec_t din,
  output logic        full,
  output logic        empty,
  output retire_rec_t head
);
  localparam int AW = $clog2(DEPTH);
  retire_rec_t     mem [DEPTH];
  logic [AW-1:0]   wp, rp, rp_n;
  logic [AW:0]     cnt;
  logic            do_push, do_pop;
  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rp_n    = rp + AW'(do_pop);
  // A push landing exactly at the new read slot must bypass into the head register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      head <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      rp   <= rp_n;
      cnt  <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      head <= (do_push && wp == rp_n) ? din : mem[rp_n];
    end
endmodule

// File: rtl/retire_trace_pipe.sv
// retire_trace_pipe: stall/flush-aware shadow pipeline emitting one record per committed instruction
module retire_trace_pipe
  import retire_trace_pkg::*;
#(
  parameter int STAGES     = 5,
  parameter int CAP_STAGE  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = RT_XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [XLEN-1:0]   fetch_pc,
  input  logic [XLEN-1:0]   fetch_instr,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  input  instr_type_t       dec_type,
  input  logic [4:0]        dec_rs,
  input  logic [4:0]        dec_rt,
  input  logic [4:0]        dec_rd,
  input  logic [XLEN-1:0]   cap_rs_val,
  input  logic [XLEN-1:0]   cap_rt_val,
  input  logic              wb_wr_en,
  input  logic [XLEN-1:0]   wb_wr_data,
  output logic              rec_valid,
  input  logic              rec_ready,
  output retire_rec_t       rec,
  output logic              overflow,
  output logic [31:0]       retire_count
);
  localparam int L = STAGES - 1;
  retire_rec_t       e   [STAGES];
  retire_rec_t       fwd [STAGES];
  retire_rec_t       fe, r;
  logic [STAGES-1:0] v, ve, hold;
  logic              ret, pop, full, empty;
  assign ve = v & ~flush;
  always_comb begin
    hold[L] = stall[L];
    for (int s = L - 1; s >= 0; s--) hold[s] = hold[s+1] | stall[s];
  end
  // fwd[s] is the entry as it leaves slot s, with decode/operand fields captured on the way out
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      fwd[s] = e[s];
      if (s == 1) begin
        fwd[s].itype = dec_type;
        fwd[s].rs    = dec_rs;
        fwd[s].rt    = dec_rt;
        fwd[s].rd    = dec_rd;
      end
      if (s == CAP_STAGE) begin
        fwd[s].rs_val = cap_rs_val;
        fwd[s].rt_val = cap_rt_val;
      end
    end
  end
  always_comb begin
    fe       = '0;
    fe.pc    = fetch_pc;
    fe.instr = fetch_instr;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v <= '0;
      for (int s = 0; s < STAGES; s++) e[s] <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++)
        if (hold[s]) v[s] <= ve[s];
        else if (s == 0) begin
          v[s] <= fetch_valid;
          e[s] <= fe;
        end else if (hold[s-1]) v[s] <= 1'b0;
        else begin
          v[s] <= ve[s-1];
          e[s] <= fwd[s-1];
        end
    end
  assign ret       = ve[L] & ~stall[L];
  assign rec_valid = ~empty;
  assign pop       = rec_valid & rec_ready;
  always_comb begin
    r          = e[L];
    r.dest_wr  = wb_wr_en;
    r.dest_val = wb_wr_en ? wb_wr_data : '0;
  end
  retire_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ret),
    .pop   (pop),
    .din   (r),
    .full  (full),
    .empty (empty),
    .head  (rec)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      overflow     <= 1'b0;
      retire_count <= '0;
    end else begin
      if (ret & full & ~pop) overflow <= 1'b1;
      if (ret) retire_count <= retire_count + 32'd1;
    end
endmodule

// File: tb/tb_retire_trace_pipe.sv
// tb_retire_trace_pipe: directed and random checks against a per-instruction reference model
module tb_retire_trace_pipe;
  import retire_trace_pkg::*;
  localparam int ST = 5, CAP = 2, DEP = 4, L = ST - 1;
  logic        clk_tb = 1'b0;
  logic        reset  = 1'b0;
  logic        fetch_valid, wb_wr_en, rec_valid, rec_ready, overflow;
  logic [31:0] fetch_pc, fetch_instr, cap_rs_val, cap_rt_val, wb_wr_data, retire_count;
  logic [ST-1:0] stall, flush;
  instr_type_t dec_type;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  retire_rec_t rec;
  int total = 0, bad = 0;
  always #5 clk_tb = ~clk_tb;
  retire_trace_pipe #(.STAGES(ST), .CAP_STAGE(CAP), .FIFO_DEPTH(DEP), .XLEN(32)) dut (
    .clk(clk_tb), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .stall(stall), .flush(flush), .dec_type(dec_type),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .cap_rs_val(cap_rs_val),
    .cap_rt_val(cap_rt_val), .wb_wr_en(wb_wr_en), .wb_wr_data(wb_wr_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec(rec), .overflow(overflow),
    .retire_count(retire_count)
  );
  // Model: each in-flight instruction carries its own slot position; records sit in a queue
  typedef struct {
    int          pos;
    retire_rec_t e;
  } item_t;
  item_t       q[$];
  retire_rec_t mq[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cnt = '0;
  function automatic bit held(int p);
    for (int s = p; s < ST; s++) if (stall[s]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(string tag, logic [191:0] got, logic [191:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask
  task automatic model_step();
    item_t       nq[$];
    item_t       it;
    retire_rec_t r;
    bit          ret, pop, acc;
    ret = 1'b0;
    acc = 1'b0;
    r   = '0;
    pop = mq.size() != 0 && rec_ready;
    foreach (q[i]) begin
      it = q[i];
      if (!flush[it.pos]) begin
        if (it.pos == L && !stall[L]) begin
          r          = it.e;
          r.dest_wr  = wb_wr_en;
          r.dest_val = wb_wr_en ? wb_wr_data : 32'd0;
          ret        = 1'b1;
        end else begin
          if (!held(it.pos)) begin
            if (it.pos == 1) begin
              it.e.itype = dec_type;
              it.e.rs    = dec_rs;
              it.e.rt    = dec_rt;
              it.e.rd    = dec_rd;
            end
            if (it.pos == CAP) begin
              it.e.rs_val = cap_rs_val;
              it.e.rt_val = cap_rt_val;
            end
            it.pos++;
          end
          nq.push_back(it);
        end
      end
    end
    if (!held(0) && fetch_valid) begin
      it.pos     = 0;
      it.e       = '0;
      it.e.pc    = fetch_pc;
      it.e.instr = fetch_instr;
      nq.push_back(it);
    end
    q = nq;
    if (ret) begin
      m_cnt++;
      acc = mq.size() < DEP || pop;
      if (!acc) m_ovf = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (ret && acc) mq.push_back(r);
  endtask
  task automatic tick();
    model_step();
    @(posedge clk_tb);
    #1;
    chk("valid", 192'(rec_valid), 192'(mq.size() != 0));
    if (mq.size() != 0) chk("rec", 192'(rec), 192'(mq[0]));
    chk("overflow", 192'(overflow), 192'(m_ovf));
    chk("count", 192'(retire_count), 192'(m_cnt));
  endtask
  task automatic idle();
    fetch_valid = 1'b0;
    fetch_pc    = '0;
    fetch_instr = '0;
    stall       = '0;
    flush       = '0;
    dec_type    = T_R;
    dec_rs      = '0;
    dec_rt      = '0;
    dec_rd      = '0;
    cap_rs_val  = '0;
    cap_rt_val  = '0;
    wb_wr_en    = 1'b0;
    wb_wr_data  = '0;
    rec_ready   = 1'b1;
  endtask
  task automatic fetch(logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_instr = pc ^ 32'h2400_A5A5;
    tick();
    fetch_valid = 1'b0;
  endtask
  initial begin
    int  n;
    bit  found;
    idle();
    @(posedge clk_tb);
    #1;
    chk("rst_valid", 192'(rec_valid), 192'(0));
    chk("rst_rec", 192'(rec), 192'(0));
    chk("rst_ovf", 192'(overflow), 192'(0));
    chk("rst_cnt", 192'(retire_count), 192'(0));
    model_reset();
    reset = 1'b1;
    // back-to-back fetches, no stalls
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    repeat (8) tick();
    chk("t1_cnt", 192'(retire_count), 192'(3));
    // stall slot 2 for two cycles while 0x10 sits there
    fetch(32'h10);
    repeat (2) tick();
    stall = 5'b00100;
    repeat (2) tick();
    stall = '0;
    repeat (8) tick();
    chk("t2_cnt", 192'(retire_count), 192'(4));
    // mispredict kills the two youngest entries
    fetch(32'h30); fetch(32'h34); fetch(32'h38);
    flush = 5'b00011;
    tick();
    flush = '0;
    repeat (8) tick();
    chk("t3_cnt", 192'(retire_count), 192'(5));
    // operand and destination capture
    dec_rs     = 5'd3;
    cap_rs_val = 32'hDEAD;
    wb_wr_en   = 1'b1;
    wb_wr_data = 32'h55;
    fetch(32'h20);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (rec_valid) found = 1'b1;
    end
    chk("t4_found", 192'(found), 192'(1));
    chk("t4_pc", 192'(rec.pc), 192'(32'h20));
    chk("t4_rs", 192'(rec.rs), 192'(3));
    chk("t4_rs_val", 192'(rec.rs_val), 192'(32'hDEAD));
    chk("t4_dest_val", 192'(rec.dest_val), 192'(32'h55));
    chk("t4_dest_wr", 192'(rec.dest_wr), 192'(1));
    idle();
    repeat (3) tick();
    // backpressure: five retirements into a four-entry buffer
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) fetch(32'h100 + 32'(4 * i));
    repeat (8) tick();
    chk("t5_ovf", 192'(overflow), 192'(1));
    chk("t5_cnt", 192'(retire_count), 192'(11));
    rec_ready = 1'b1;
    n = 0;
    repeat (6) begin
      if (rec_valid) n++;
      tick();
    end
    chk("t5_drain", 192'(n), 192'(4));
    // asynchronous reset with records buffered and entries in flight
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) fetch(32'h200 + 32'(4 * i));
    repeat (2) tick();
    chk("t6_pre_cnt", 192'(retire_count), 192'(13));
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 192'(rec_valid), 192'(0));
    chk("t6_rec", 192'(rec), 192'(0));
    chk("t6_ovf", 192'(overflow), 192'(0));
    chk("t6_cnt", 192'(retire_count), 192'(0));
    model_reset();
    @(posedge clk_tb);
    #1;
    reset     = 1'b1;
    rec_ready = 1'b1;
    repeat (8) tick();
    chk("t6_post_cnt", 192'(retire_count), 192'(0));
    // random traffic
    for (int i = 0; i < 400; i++) begin
      fetch_valid = $urandom_range(0, 3) != 0;
      fetch_pc    = $urandom;
      fetch_instr = $urandom;
      stall       = ST'($urandom & $urandom & $urandom);
      flush       = ST'($urandom & $urandom & $urandom & $urandom);
      dec_type    = instr_type_t'($urandom_range(0, 3));
      dec_rs      = 5'($urandom);
      dec_rt      = 5'($urandom);
      dec_rd      = 5'($urandom);
      cap_rs_val  = $urandom;
      cap_rt_val  = $urandom;
      wb_wr_en    = $urandom_range(0, 1) == 1;
      wb_wr_data  = $urandom;
      rec_ready   = $urandom_range(0, 3) != 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/retire_trace_pipe.md
# retire_trace_pipe

Parametrised shadow pipeline that carries per-instruction trace metadata (pc, instr, type, register indices, operand values, destination value) alongside the MIPS core pipeline. It tracks the core's stalls and flushes and emits one retirement record per committed instruction into a ready/valid buffer for the co-simulation checker. It sits beside `top` and replaces free-running shift-register tracking, which has no stall or flush awareness and no record buffering.

## Interface
- `STAGES`, 5: pipeline depth; slot 0 = fetch, slot `STAGES-1` = write-back; minimum 4.
- `CAP_STAGE`, 2: slot whose `cap_*` values are latched; legal range 2..`STAGES-2`.
- `FIFO_DEPTH`, 4: retirement record buffer entries; power of two, at least 2.
- `XLEN`, 32: data and pc width.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `fetch_valid`  in  1  a fetched instruction is presented.
- `fetch_pc`, `fetch_instr`  in  XLEN  fetch pc and instruction.
- `stall`  in  STAGES  per-slot stall request.
- `flush`  in  STAGES  per-slot kill.
- `dec_type`  in  2  `instr_type_t` of the slot-1 entry.
- `dec_rs`, `dec_rt`, `dec_rd`  in  5 each  register indices of the slot-1 entry.
- `cap_rs_val`, `cap_rt_val`  in  XLEN  operand values of the `CAP_STAGE` entry.
- `wb_wr_en`  in  1  last-slot entry writes the register file.
- `wb_wr_data`  in  XLEN  write-back data.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  checker accepts the record.
- `rec`  out  `retire_rec_t`  head record.
- `overflow`  out  1  sticky: a retirement was dropped.
- `retire_count`  out  32  committed instructions since reset.

## Operation
- Each slot s holds `v[s]` plus an entry. Effective valid: `ve[s] = v[s] & ~flush[s]`.
- Hold: `hold[s] = |stall[STAGES-1:s]`. A stall in any slot freezes that slot and all younger slots.
- Slot 0:
  - if `hold[0]`, keeps its entry with `v <= ve[0]`;
  - else loads `fetch_*` with `v <= fetch_valid`.
- Slot s>0:
  - if `hold[s]`, keeps its entry with `v <= ve[s]`;
  - else if `hold[s-1]`, receives a bubble (`v <= 0`);
  - else loads slot s-1 with `v <= ve[s-1]`.
- Field capture on advance:
  - slot 1 → 2 loads type and indices from `dec_*`;
  - slot `CAP_STAGE` → `CAP_STAGE+1` loads `rs_val`/`rt_val` from `cap_*`.
  - All other fields are copied unchanged.
- Retire condition: `ve[STAGES-1] & ~stall[STAGES-1]`. On retire:
  - build a record with `dest_wr = wb_wr_en` and `dest_val = wb_wr_en ? wb_wr_data : 0`;
  - push the record;
  - increment `retire_count`, which wraps at 2^32.
- Push while full with no pop in the same cycle: record is dropped, `overflow` is set and stays set until reset.
- Push while full with a pop in the same cycle: push is accepted.
- Pop happens when `rec_valid & rec_ready`.
- Flushed or bubble entries never retire and never reach the FIFO.

## Timing
- Reset values:
  - all `v` = 0, all entries 0;
  - `rec_valid` = 0, `rec` = 0;
  - `overflow` = 0, `retire_count` = 0;
  - FIFO pointers = 0.
- With no stalls, an instruction presented at edge k retires at edge k+`STAGES`.
- FIFO latency: a record pushed at edge n drives `rec_valid` after edge n (registered head, no fall-through). Empty FIFO never shows valid.
- `rec` is stable while `rec_valid & ~rec_ready`.
- `flush[s]` and `stall[s]` asserted together: the slot becomes a held bubble.
- Reset asserted mid-operation clears everything immediately (asynchronous); pending records are lost and no retirement is counted.

## Structure
- `retire_trace_pkg`:
  - `instr_type_t` (R=0, I=1, J=2, NONE=3);
  - `retire_rec_t` {pc, instr, type, rs, rt, rd, rs_val, rt_val, dest_val, dest_wr};
  - XLEN default constant.
- Sub-module `retire_trace_fifo`: parametrised synchronous FIFO of `retire_rec_t` with full/empty flags and a registered head.

## Test plan
- No stalls, STAGES=5: pc 0x0, 0x4, 0x8 on consecutive cycles with `rec_ready`=1 → records appear 5, 6, 7 cycles later in order; `retire_count`=3.
- `stall[2]` held for 2 cycles with pc 0x10 in slot 2 → slots 0–2 frozen, slot 3 gets bubbles, record for 0x10 delayed exactly 2 cycles, no duplicate record.
- `flush[1]` and `flush[0]` asserted for one cycle (branch mispredict) → the two younger entries never retire; `retire_count` excludes them.
- Operands: `dec_rs`=3 while pc 0x20 is in slot 1, `cap_rs_val`=0xDEAD while it is in slot 2, `wb_wr_en`=1 with `wb_wr_data`=0x55 → record {rs=3, rs_val=0xDEAD, dest_val=0x55, dest_wr=1}.
- `rec_ready`=0 with 5 retirements and FIFO_DEPTH=4 → 4 records held, `overflow`=1, `retire_count`=5; then `rec_ready`=1 → exactly 4 records drain in order.
- Reset asserted while 3 entries are in flight and 2 are buffered → all outputs return to 0 asynchronously; no records after release until new fetches arrive.
